// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths, register-index constants and types for the
//               MIPS single-cycle datapath register file.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    // Fixed relation: one architectural register per address code.
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    // $zero is hardwired; $ra is the JAL link target.
    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/reg_file_write_bank_decoder.sv
`default_nettype none
// ============================================================================
// Module      : decoder5to32
// Description : Write-address decoder. Turns an enable plus a 5-bit register
//               index into a one-hot write strobe. The strobe is all-zero when
//               the enable is low or the index does not match any code (an
//               unknown index compares false against every code).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder5to32
    import mips_pkg::*;
(
    input  logic                en_i,
    input  reg_idx_t            idx_i,
    output logic [NUM_REGS-1:0] strobe_o
);

    // One-hot decode gated by the enable; no match leaves every strobe low.
    always_comb begin
        strobe_o = '0;
        if (en_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_i == reg_idx_t'(i)) begin
                    strobe_o[i] = 1'b1;
                end
            end
        end
    end

endmodule : decoder5to32
`default_nettype wire

// File: rtl/reg_file_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_write_bank
// Description : Write side of the MIPS register file. Holds the 32
//               architectural registers in individual flop banks and presents
//               them all on a flat bus for the rs/rt read-select muxes.
//               Register 0 is hardwired to zero. WriteAck pulses the cycle
//               after each committed write.
//               Build option REG_WRITE_FORWARD_EN: when defined, the slice of
//               the register being written shows WriteData combinationally
//               (write-before-read); stored state is the same either way.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_write_bank
    import mips_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         RegWrite,
    input  logic [ADDR_W-1:0]            WriteReg,
    input  logic [DATA_W-1:0]            WriteData,
    output logic [NUM_REGS*DATA_W-1:0]   RegOut,
    output logic                         WriteAck
);

    // Bit 0 of the decoded strobe is forced low so $zero can never be written.
    localparam logic [NUM_REGS-1:0] ZERO_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    logic [NUM_REGS-1:0] w_dec_strobe;
    logic [NUM_REGS-1:0] w_wr_strobe;
    logic                ack_d;
    logic                ack_q;

    decoder5to32 u_decoder (
        .en_i     (RegWrite),
        .idx_i    (WriteReg),
        .strobe_o (w_dec_strobe)
    );

    assign w_wr_strobe = w_dec_strobe & ZERO_MASK;

    // A write commits only when some non-zero register is actually strobed,
    // so index 0 and unknown indices never acknowledge.
    assign ack_d = |w_wr_strobe;

    // Acknowledge flop: one pulse per committed write, level across bursts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign WriteAck = ack_q;

    // $zero: no storage, constant zero on the bus.
    generate
        if (1) begin : g_zero_reg
            assign RegOut[DATA_W-1:0] = '0;
        end
    endgenerate

    // One enabled flop bank per writable register, packed onto the flat bus.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_regs
            word_t reg_q;

            // Load WriteData when this register's strobe is high, else hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else if (w_wr_strobe[gi]) begin
                    reg_q <= WriteData;
                end
            end

`ifdef REG_WRITE_FORWARD_EN
            assign RegOut[gi*DATA_W +: DATA_W] = w_wr_strobe[gi] ? WriteData : reg_q;
`else
            assign RegOut[gi*DATA_W +: DATA_W] = reg_q;
`endif
        end
    endgenerate

endmodule : reg_file_write_bank
`default_nettype wire

// File: tb/tb_reg_file_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_write_bank
// Description : Directed, table-driven self-checking bench for
//               reg_file_write_bank, plus hand-written reset, forwarding and
//               sweep sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_write_bank;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          RegWrite;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic [1023:0] RegOut;
    logic          WriteAck;

    int total = 0;
    int bad   = 0;

    logic [31:0] shadow [32];

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          slot;
        logic [31:0] exp_val;
        logic        exp_ack;
    } vec_t;

    vec_t vecs [8];

    reg_file_write_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegOut    (RegOut),
        .WriteAck  (WriteAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s_slice%0d", tag, i), RegOut[i*32 +: 32], shadow[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    endtask

    initial begin
        int acks;

        vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 8,  32'hDEAD_BEEF, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 0,  32'h0000_0000, 1'b0};
        vecs[2] = '{1'b0, 5'd31, 32'h1234_5678, 31, 32'h0000_0000, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 32'hCAFE_F00D, 31, 32'hCAFE_F00D, 1'b1};
        vecs[4] = '{1'b1, 5'd31, 32'h1111_2222, 31, 32'h1111_2222, 1'b1};
        vecs[5] = '{1'b0, 5'd8,  32'h0000_0000, 8,  32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{1'b1, 5'd1,  32'h0000_0001, 1,  32'h0000_0001, 1'b1};
        vecs[7] = '{1'b1, 5'd0,  32'h0BAD_0BAD, 0,  32'h0000_0000, 1'b0};

        // Reset from power-up, checked before any clock edge.
        rst_n     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = 5'd0;
        WriteData = 32'h0;
        clear_shadow();
        #1;
        chk_all("por");
        chk("por_ack", {31'h0, WriteAck}, 32'h0);
        tick();
        rst_n = 1'b1;

        // Table-driven single writes.
        for (int v = 0; v < 8; v++) begin
            RegWrite  = vecs[v].we;
            WriteReg  = vecs[v].addr;
            WriteData = vecs[v].data;
            tick();
            shadow[vecs[v].slot] = vecs[v].exp_val;
            chk_all($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_ack", v), {31'h0, WriteAck}, {31'h0, vecs[v].exp_ack});
        end
        RegWrite = 1'b0;

        // Forwarding: slice 5 before the edge depends on the build option.
        RegWrite  = 1'b1;
        WriteReg  = 5'd5;
        WriteData = 32'hA5A5_A5A5;
        #1;
`ifdef REG_WRITE_FORWARD_EN
        chk("fwd_pre_edge", RegOut[5*32 +: 32], 32'hA5A5_A5A5);
`else
        chk("fwd_pre_edge", RegOut[5*32 +: 32], 32'h0000_0000);
`endif
        tick();
        shadow[5] = 32'hA5A5_A5A5;
        chk("fwd_post_edge", RegOut[5*32 +: 32], 32'hA5A5_A5A5);
        chk("fwd_ack", {31'h0, WriteAck}, 32'h1);

        // Random content in reg 20, then async reset between edges.
        WriteReg  = 5'd20;
        WriteData = $urandom;
        tick();
        RegWrite = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        clear_shadow();
        chk_all("async_rst");
        chk("async_rst_ack", {31'h0, WriteAck}, 32'h0);

        // Writes attempted while reset is held must be ignored.
        RegWrite  = 1'b1;
        WriteReg  = 5'd3;
        WriteData = 32'h3333_3333;
        tick();
        chk("rst_hold_slice3", RegOut[3*32 +: 32], 32'h0);
        chk("rst_hold_ack", {31'h0, WriteAck}, 32'h0);
        rst_n = 1'b1;

        // Back-to-back sweep over regs 1..31; first write lands on the
        // first edge after release.
        acks = 0;
        for (int i = 1; i < 32; i++) begin
            RegWrite  = 1'b1;
            WriteReg  = 5'(i);
            WriteData = 32'(i) * 32'h0101_0101;
            tick();
            shadow[i] = 32'(i) * 32'h0101_0101;
            chk($sformatf("sweep_ack%0d", i), {31'h0, WriteAck}, 32'h1);
            if (WriteAck === 1'b1) acks++;
        end
        RegWrite = 1'b0;
        tick();
        chk("sweep_ack_count", 32'(acks), 32'd31);
        chk("sweep_ack_drop", {31'h0, WriteAck}, 32'h0);
        chk_all("sweep");

        // Second sweep interrupted by an async reset mid-cycle.
        for (int i = 1; i <= 16; i++) begin
            RegWrite  = 1'b1;
            WriteReg  = 5'(i);
            WriteData = ~(32'(i) * 32'h0101_0101);
            tick();
        end
        chk("midsweep_slice16", RegOut[16*32 +: 32], ~(32'd16 * 32'h0101_0101));
        #2;
        rst_n = 1'b0;
        #1;
        clear_shadow();
        chk_all("midsweep_rst");
        chk("midsweep_rst_ack", {31'h0, WriteAck}, 32'h0);
        RegWrite = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_write_bank
`default_nettype wire
